// File: rtl/filt_single_collector.sv
// filt_single_collector: receives single filter taps (most-significant tap first),
// repeated NUM_REPS times. It rebuilds the packed frame from the first pass,
// checks every later pass against that copy, and presents the frame with a
// mismatch flag on a valid/ready output port.
module filt_single_collector #(
  parameter int DWIDTH   = 8,
  parameter int NUM_TAPS = 3,
  parameter int NUM_REPS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         single_valid,
  output logic                         single_ready,
  input  logic [DWIDTH-1:0]            single_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [DWIDTH*NUM_TAPS-1:0]   frame_data,
  output logic                         frame_mismatch,
  output logic                         err_sticky,
  output logic [15:0]                  frame_count
);

  localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int RW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [TW-1:0]     tap_idx;
  logic [RW-1:0]     rep_idx;
  logic              take;
  logic              last_tap;
  logic              tap_wrap;
  logic              send_done;
  logic              tap_differs;
  logic [DWIDTH-1:0] stored_tap;

  assign take      = single_valid && single_ready;
  assign tap_wrap  = (tap_idx == TW'(NUM_TAPS - 1));
  assign last_tap  = tap_wrap && (rep_idx == RW'(NUM_REPS - 1));
  assign send_done = (state == SEND) && frame_ready;

  // Select the first-pass value stored for the current tap position and compare it.
  always_comb begin
    stored_tap  = frame_data[(NUM_TAPS - 1 - int'(tap_idx)) * DWIDTH +: DWIDTH];
    tap_differs = (rep_idx != '0) && (single_data != stored_tap);
  end

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: IDLE leaves unconditionally, COLLECT ends on the final tap, SEND on handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = COLLECT;
      COLLECT: if (take && last_tap) next_state = SEND;
      SEND:    if (frame_ready) next_state = COLLECT;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state; ready waits one extra edge out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_ready <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      single_ready <= (next_state == COLLECT) && (state != IDLE);
      frame_valid  <= (next_state == SEND);
    end
  end

  // Tap/pass counters, frame capture on pass 0, comparison on later passes, delivery bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx        <= '0;
      rep_idx        <= '0;
      frame_data     <= '0;
      frame_mismatch <= 1'b0;
      err_sticky     <= 1'b0;
      frame_count    <= 16'd0;
    end else if (take) begin
      if (rep_idx == '0) begin
        frame_data[(NUM_TAPS - 1 - int'(tap_idx)) * DWIDTH +: DWIDTH] <= single_data;
      end else if (tap_differs) begin
        frame_mismatch <= 1'b1;
        err_sticky     <= 1'b1;
      end
      if (tap_wrap) begin
        tap_idx <= '0;
        rep_idx <= last_tap ? '0 : rep_idx + RW'(1);
      end else begin
        tap_idx <= tap_idx + TW'(1);
      end
    end else if (send_done) begin
      frame_count    <= frame_count + 16'd1;
      frame_mismatch <= 1'b0;
      tap_idx        <= '0;
      rep_idx        <= '0;
    end
  end

endmodule

// File: tb/tb_filt_single_collector.sv
// Self-checking bench for filt_single_collector: a table of directed frames,
// a mid-stream reset check, and randomized frames scored against a simple model.
module tb_filt_single_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        single_valid = 1'b0;
  logic        single_ready;
  logic [7:0]  single_data = 8'h00;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [23:0] frame_data;
  logic        frame_mismatch;
  logic        err_sticky;
  logic [15:0] frame_count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_err = 1'b0;

  typedef struct {
    logic [71:0] taps;
    int          hold;
    bit          pulse;
    logic [23:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[6];

  filt_single_collector #(.DWIDTH(8), .NUM_TAPS(3), .NUM_REPS(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .single_valid(single_valid),
    .single_ready(single_ready),
    .single_data(single_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data(frame_data),
    .frame_mismatch(frame_mismatch),
    .err_sticky(err_sticky),
    .frame_count(frame_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " single_ready"}, 32'(single_ready), 32'd0);
    checkOutput({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
    checkOutput({tag, " frame_data"}, 32'(frame_data), 32'd0);
    checkOutput({tag, " frame_mismatch"}, 32'(frame_mismatch), 32'd0);
    checkOutput({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
    checkOutput({tag, " frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // Release reset at a falling edge and check single_ready timing; ends on a falling edge.
  task automatic releaseReset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready after edge 1", 32'(single_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready after edge 2", 32'(single_ready), 32'd1);
    @(negedge clk);
  endtask

  // Sends nine taps (first tap in the top byte), then checks and accepts the frame.
  // Entered and left just after a falling edge.
  task automatic applyStimulus(input logic [71:0] taps, input int max_gap, input int hold,
                               input bit pulse, input logic [23:0] exp_data, input logic exp_mis);
    bit          done;
    bit          got;
    int          gap;
    logic [23:0] held_data;
    logic        held_mis;
    for (int i = 0; i < 9; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) @(negedge clk);
      single_valid = 1'b1;
      single_data  = taps[71 - 8*i -: 8];
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
        got = single_ready;
        @(negedge clk);
        if (got) done = 1'b1;
      end
      single_valid = 1'b0;
      if (!done) begin
        checkOutput("tap accept timeout", 32'd0, 32'd1);
        return;
      end
    end
    for (int c = 0; c < 20 && !frame_valid; c++) @(negedge clk);
    if (!frame_valid) begin
      checkOutput("frame_valid timeout", 32'd0, 32'd1);
      return;
    end
    exp_err = exp_err | exp_mis;
    checkOutput("frame_data", 32'(frame_data), 32'(exp_data));
    checkOutput("frame_mismatch", 32'(frame_mismatch), 32'(exp_mis));
    checkOutput("err_sticky", 32'(err_sticky), 32'(exp_err));
    checkOutput("count before handshake", 32'(frame_count), 32'(exp_count));
    checkOutput("ready in send", 32'(single_ready), 32'd0);
    held_data = frame_data;
    held_mis  = frame_mismatch;
    for (int s = 0; s < hold; s++) begin
      if (pulse) begin
        single_valid = 1'($urandom_range(1, 0));
        single_data  = 8'hEE;
      end
      @(negedge clk);
      checkOutput("stall valid", 32'(frame_valid), 32'd1);
      checkOutput("stall data", 32'(frame_data), 32'(held_data));
      checkOutput("stall mismatch", 32'(frame_mismatch), 32'(held_mis));
      checkOutput("stall ready", 32'(single_ready), 32'd0);
    end
    single_valid = 1'b0;
    frame_ready  = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checkOutput("valid after handshake", 32'(frame_valid), 32'd0);
    checkOutput("count after handshake", 32'(frame_count), 32'(exp_count));
    checkOutput("ready after handshake", 32'(single_ready), 32'd1);
    checkOutput("mismatch cleared", 32'(frame_mismatch), 32'd0);
  endtask

  // Random-phase locals.
  logic [7:0]  rtaps [9];
  logic [71:0] rpacked;
  logic [23:0] rexp;
  logic        rmis;
  int          corrupt;

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vecs[0] = '{72'h112233_112233_112233, 0, 1'b0, 24'h112233, 1'b0};
    vecs[1] = '{72'h112233_112A33_112233, 0, 1'b0, 24'h112233, 1'b1};
    vecs[2] = '{72'h112233_112233_112233, 0, 1'b0, 24'h112233, 1'b0};
    vecs[3] = '{72'h5A6B7C_5A6B7C_5A6B7C, 5, 1'b1, 24'h5A6B7C, 1'b0};
    vecs[4] = '{72'h112233_112233_112234, 0, 1'b0, 24'h112233, 1'b1};
    vecs[5] = '{72'hA1B2C3_A1B2C3_A1B2C3, 0, 1'b0, 24'hA1B2C3, 1'b0};

    #1;
    checkAllZero("power-on reset");
    @(negedge clk);
    @(negedge clk);
    releaseReset();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].taps, 0, vecs[v].hold, vecs[v].pulse, vecs[v].exp_data, vecs[v].exp_mis);
    end

    single_valid = 1'b1;
    single_data  = 8'h77;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("mid-stream reset");
    single_valid = 1'b0;
    @(negedge clk);
    exp_count = 16'd0;
    exp_err   = 1'b0;
    releaseReset();

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 3; k++) rtaps[k] = 8'($urandom);
      for (int k = 3; k < 9; k++) rtaps[k] = rtaps[k % 3];
      if ($urandom_range(2, 0) == 0) begin
        corrupt = int'($urandom_range(8, 3));
        rtaps[corrupt] = rtaps[corrupt] ^ 8'($urandom_range(255, 1));
      end
      rexp = {rtaps[0], rtaps[1], rtaps[2]};
      rmis = 1'b0;
      for (int k = 3; k < 9; k++) if (rtaps[k] != rtaps[k % 3]) rmis = 1'b1;
      rpacked = '0;
      for (int k = 0; k < 9; k++) rpacked[71 - 8*k -: 8] = rtaps[k];
      applyStimulus(rpacked, 4, int'($urandom_range(2, 0)), 1'b1, rexp, rmis);
    end
    checkOutput("count after 20 random frames", 32'(frame_count), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
